// File: rtl/in_reg_bank.sv
// in_reg_bank: multi-channel pad input capture with synchroniser, global hold, per-channel bypass
// and registered rise/fall pulses. Define IN_REG_BANK_FILTER_EN to build the per-channel glitch filter.
module in_reg_bank #(
    parameter int   WIDTH       = 8,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYCLES = 4,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] sel,
    input  logic             hold,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             valid
);
    localparam logic [WIDTH-1:0] RST_WORD = {WIDTH{RST_VAL}};
    localparam int               VALID_AT = SYNC_STAGES + 1;
    localparam int               VCNT_W   = $clog2(VALID_AT + 1);

    if (WIDTH < 1 || WIDTH > 64 || SYNC_STAGES < 1 || SYNC_STAGES > 4 ||
        FILT_CYCLES < 1 || FILT_CYCLES > 15) begin : g_bad_param
        $error("in_reg_bank: parameter out of range");
    end

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  s;
    logic [WIDTH-1:0]                  q;
    logic [WIDTH-1:0]                  q_next;
    logic [VCNT_W-1:0]                 vcnt;

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: non-blocking assignments make every stage sample its neighbour's pre-edge value,
    // so the chain shifts by exactly one stage per edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_WORD}};
        end else if (!hold) begin
            sync_q[0] <= data_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

`ifdef IN_REG_BANK_FILTER_EN
    localparam logic [3:0] CNT_MAX = 4'(FILT_CYCLES - 1);

    logic [WIDTH-1:0][3:0] cnt;
    logic [WIDTH-1:0][3:0] cnt_next;

    // A new level at s is accepted only after FILT_CYCLES consecutive un-held edges.
    // NOTE: defaults assigned first so no branch leaves an output unassigned (no latch).
    always_comb begin
        q_next   = q;
        cnt_next = cnt;
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == q[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] < CNT_MAX) begin
                cnt_next[i] = cnt[i] + 4'd1;
            end else begin
                q_next[i]   = s[i];
                cnt_next[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= cnt_next;
        end
    end
`else
    assign q_next = s;
`endif

    // Pulses compare q against the value it loads this edge, so they align with q's first new cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= RST_WORD;
            rise <= '0;
            fall <= '0;
        end else if (hold) begin
            rise <= '0;
            fall <= '0;
        end else begin
            q    <= q_next;
            rise <= ~q & q_next;
            fall <= q & ~q_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vcnt <= '0;
        end else if (!hold && vcnt != VCNT_W'(VALID_AT)) begin
            vcnt <= vcnt + VCNT_W'(1);
        end
    end

    assign valid    = (vcnt == VCNT_W'(VALID_AT));
    assign data_out = (sel & data_in) | (~sel & q);

endmodule

// File: tb/tb_in_reg_bank.sv
// Directed bench for in_reg_bank: dut_a (FILT_CYCLES=1, no-filter timing in either build) runs the
// vector table; dut_b (FILT_CYCLES=4) runs the filter/hold/reset sequences with build-dependent expectations.
module tb_in_reg_bank;
`ifdef IN_REG_BANK_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    typedef struct {
        logic [7:0] din;
        logic [7:0] sel;
        logic       hold;
        logic [7:0] out;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       valid;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] din = 8'h00;
    logic [7:0] sel = 8'h00;
    logic       hold = 1'b0;
    logic [7:0] out_a, rise_a, fall_a, out_b, rise_b, fall_b;
    logic       valid_a, valid_b;

    int n_checks = 0;
    int n_pass   = 0;

    in_reg_bank #(.WIDTH(8), .SYNC_STAGES(2), .FILT_CYCLES(1), .RST_VAL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(din), .sel(sel), .hold(hold),
        .data_out(out_a), .rise(rise_a), .fall(fall_a), .valid(valid_a)
    );

    in_reg_bank #(.WIDTH(8), .SYNC_STAGES(2), .FILT_CYCLES(4), .RST_VAL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(din), .sel(sel), .hold(hold),
        .data_out(out_b), .rise(rise_b), .fall(fall_b), .valid(valid_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        din   = 8'h00;
        sel   = 8'h00;
        hold  = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    vec_t       vecs [22];
    logic [7:0] acc_out, acc_rise, acc_fall;
    logic [7:0] out_at5, rise_upd;
    logic       v_at1, v_at2, held_valid;
    int         first, nrise, nfall, n;

    initial begin
        // din, sel, hold | out, rise, fall, valid  (dut_a, one edge per row)
        vecs = '{
            '{8'hA5, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0},
            '{8'hA5, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0},
            '{8'hA5, 8'h00, 1'b0, 8'hA5, 8'hA5, 8'h00, 1'b1},
            '{8'hA5, 8'h00, 1'b0, 8'hA5, 8'h00, 8'h00, 1'b1},
            '{8'h3C, 8'h00, 1'b0, 8'hA5, 8'h00, 8'h00, 1'b1},
            '{8'h3C, 8'h00, 1'b0, 8'hA5, 8'h00, 8'h00, 1'b1},
            '{8'h3C, 8'h00, 1'b0, 8'h3C, 8'h18, 8'h81, 1'b1},
            '{8'hFF, 8'h00, 1'b1, 8'h3C, 8'h00, 8'h00, 1'b1},
            '{8'hFF, 8'h00, 1'b1, 8'h3C, 8'h00, 8'h00, 1'b1},
            '{8'hFF, 8'h00, 1'b0, 8'h3C, 8'h00, 8'h00, 1'b1},
            '{8'hFF, 8'h00, 1'b1, 8'h3C, 8'h00, 8'h00, 1'b1},
            '{8'hFF, 8'h00, 1'b0, 8'h3C, 8'h00, 8'h00, 1'b1},
            '{8'h00, 8'h00, 1'b0, 8'hFF, 8'hC3, 8'h00, 1'b1},
            '{8'h00, 8'hF0, 1'b0, 8'h0F, 8'h00, 8'h00, 1'b1},
            '{8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b1},
            '{8'h5A, 8'hFF, 1'b1, 8'h5A, 8'h00, 8'h00, 1'b1},
            '{8'h55, 8'hFF, 1'b0, 8'h55, 8'h00, 8'h00, 1'b1},
            '{8'hAA, 8'hFF, 1'b0, 8'hAA, 8'h00, 8'h00, 1'b1},
            '{8'h55, 8'hFF, 1'b0, 8'h55, 8'h55, 8'h00, 1'b1},
            '{8'hAA, 8'hFF, 1'b0, 8'hAA, 8'hAA, 8'h55, 1'b1},
            '{8'h55, 8'hFF, 1'b0, 8'h55, 8'h55, 8'hAA, 1'b1},
            '{8'h55, 8'h00, 1'b0, 8'hAA, 8'hAA, 8'h55, 1'b1}
        };

        // Reset state, before any clock edge
        #1 rst_n = 1'b0;
        din = 8'hFF;
        #1;
        check("rst out", out_a, 8'h00);
        check("rst rise", rise_a, 8'h00);
        check("rst fall", fall_a, 8'h00);
        check("rst valid", valid_a, 1'b0);
        check("rst out_b", out_b, 8'h00);
        sel = 8'h0F;
        #1;
        check("rst bypass", out_a, 8'h0F);
        tick();
        tick();
        check("rst held out", out_a, 8'h0F);
        check("rst held valid", valid_a, 1'b0);
        din   = 8'h00;
        sel   = 8'h00;
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            din  = vecs[i].din;
            sel  = vecs[i].sel;
            hold = vecs[i].hold;
            tick();
            check($sformatf("v%0d out", i), out_a, vecs[i].out);
            check($sformatf("v%0d rise", i), rise_a, vecs[i].rise);
            check($sformatf("v%0d fall", i), fall_a, vecs[i].fall);
            check($sformatf("v%0d valid", i), valid_a, vecs[i].valid);
        end

        // Bypass follows data_in between edges
        sel = 8'hFF;
        din = 8'hC3;
        #1;
        check("bypass comb", out_a, 8'hC3);

        // Short pulse: 3 cycles at s is rejected by the filter
        reset_dut();
        repeat (3) tick();
        acc_out = '0; acc_rise = '0; acc_fall = '0;
        for (int k = 0; k < 10; k++) begin
            din = (k < 3) ? 8'h01 : 8'h00;
            tick();
            acc_out  |= out_b;
            acc_rise |= rise_b;
            acc_fall |= fall_b;
        end
        check("glitch out", acc_out, FILT ? 8'h00 : 8'h01);
        check("glitch rise", acc_rise, FILT ? 8'h00 : 8'h01);
        check("glitch fall", acc_fall, FILT ? 8'h00 : 8'h01);

        // 4-cycle pulse is accepted after SYNC_STAGES+FILT_CYCLES edges
        first = -1; nrise = 0; nfall = 0; out_at5 = '0;
        for (int k = 0; k < 14; k++) begin
            din = (k < 4) ? 8'h01 : 8'h00;
            tick();
            if (rise_b[0]) begin
                nrise++;
                if (first < 0) first = k;
            end
            if (fall_b[0]) nfall++;
            if (k == 5) out_at5 = out_b;
        end
        check("pulse first rise", 32'(first), FILT ? 32'd5 : 32'd2);
        check("pulse rise count", 32'(nrise), 32'd1);
        check("pulse fall count", 32'(nfall), 32'd1);
        check("pulse out at 5", out_at5, 8'h01);
        check("pulse settled", out_b, 8'h00);

        // Hold with an acceptance pending on ch1; held edges do not count
        din = 8'h02;
        repeat (FILT ? 4 : 2) tick();
        hold = 1'b1;
        acc_out = '0; acc_rise = '0; held_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            acc_out    |= out_b;
            acc_rise   |= rise_b | fall_b;
            held_valid &= valid_b;
        end
        check("hold out frozen", acc_out, 8'h00);
        check("hold pulses", acc_rise, 8'h00);
        check("hold valid", held_valid, 1'b1);
        hold = 1'b0;
        n = 0;
        rise_upd = '0;
        while (out_b[1] !== 1'b1 && n < 8) begin
            tick();
            n++;
            rise_upd = rise_b;
        end
        check("hold release edges", 32'(n), FILT ? 32'd2 : 32'd1);
        check("hold release rise", rise_upd, 8'h02);

        // Async reset mid-filter, between edges
        din = 8'h06;
        repeat (3) tick();
        check("pre-reset out", out_b, FILT ? 8'h02 : 8'h06);
        #3 rst_n = 1'b0;
        #1;
        check("async out", out_b, 8'h00);
        check("async valid", valid_b, 1'b0);
        check("async pulses", rise_b | fall_b, 8'h00);
        tick();
        din   = 8'h00;
        rst_n = 1'b1;
        acc_out = '0; acc_rise = '0; v_at1 = 1'b1; v_at2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            acc_out  |= out_b;
            acc_rise |= rise_b | fall_b;
            if (k == 1) v_at1 = valid_b;
            if (k == 2) v_at2 = valid_b;
        end
        check("post-reset out", acc_out, 8'h00);
        check("post-reset pulses", acc_rise, 8'h00);
        check("post-reset valid e2", v_at1, 1'b0);
        check("post-reset valid e3", v_at2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
